// File: rtl/fill_cmd_queue.sv
// Buffers rectangle-fill commands and sequences them one at a time into the fill engine.
// Latency: push into idle/empty queue -> pop one edge later -> trig_o one edge after that.
// Backpressure: none upstream; a push into a full queue is dropped and flagged on ovf_o.

module fill_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LOGD  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             drop,
    output logic             full,
    output logic             empty,
    output logic [LOGD:0]    level
);
    localparam logic [LOGD:0] FULL_CNT = (LOGD+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOGD-1:0]  wr_ptr;
    logic [LOGD-1:0]  rd_ptr;
    logic [LOGD:0]    count;
    logic             pop_ok;
    logic             push_ok;

    // A pop frees its slot in the same cycle, so a full queue can still accept a push.
    assign pop_ok   = pop_vld && (count != '0);
    assign push_ok  = push_vld && ((count != FULL_CNT) || pop_ok);
    assign drop     = push_vld && !push_ok;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign level    = count;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end
endmodule

module fill_cmd_queue #(
    parameter int COLORW = 16,
    parameter int RANGEW = 9,
    parameter int DEPTH  = 4,
    parameter int LOGD   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_we_i,
    input  logic [COLORW-1:0] cmd_color_i,
    input  logic [RANGEW-1:0] cmd_x0_i,
    input  logic [RANGEW-1:0] cmd_y0_i,
    input  logic [RANGEW-1:0] cmd_width_i,
    input  logic [RANGEW-1:0] cmd_height_i,
    input  logic [RANGEW-1:0] leg_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [LOGD:0]     level_o,
    output logic [COLORW-1:0] color_o,
    output logic [RANGEW-1:0] x0_o,
    output logic [RANGEW-1:0] y0_o,
    output logic [RANGEW-1:0] width_o,
    output logic [RANGEW-1:0] height_o,
    output logic [RANGEW-1:0] leg_o,
    output logic              trig_o,
    input  logic              fill_busy_i,
    output logic              busy_o,
    output logic              ovf_o,
    output logic              irq_o,
    input  logic              irq_clear_i
);
    typedef struct packed {
        logic [COLORW-1:0] color;
        logic [RANGEW-1:0] x0;
        logic [RANGEW-1:0] y0;
        logic [RANGEW-1:0] width;
        logic [RANGEW-1:0] height;
    } cmd_t;

    localparam int CMDW = $bits(cmd_t);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_TRIG = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [1:0] state;
    cmd_t       wr_cmd;
    cmd_t       head_cmd;
    logic       pop;
    logic       fifo_drop;
    logic       done_any;

    assign wr_cmd = '{color: cmd_color_i, x0: cmd_x0_i, y0: cmd_y0_i,
                      width: cmd_width_i, height: cmd_height_i};
    assign pop    = (state == S_IDLE) && !empty_o;
    assign busy_o = (state != S_IDLE);

    fill_cmd_fifo #(
        .WIDTH (CMDW),
        .DEPTH (DEPTH),
        .LOGD  (LOGD)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (cmd_we_i),
        .push_dat (wr_cmd),
        .pop_vld  (pop),
        .head_dat (head_cmd),
        .drop     (fifo_drop),
        .full     (full_o),
        .empty    (empty_o),
        .level    (level_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            color_o  <= '0;
            x0_o     <= '0;
            y0_o     <= '0;
            width_o  <= '0;
            height_o <= '0;
            leg_o    <= '0;
            trig_o   <= 1'b0;
            done_any <= 1'b0;
            irq_o    <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            if (fifo_drop)
                ovf_o <= 1'b1;
            else if (irq_clear_i)
                ovf_o <= 1'b0;

            // Drain interrupt only once the queue is idle and empty after real work.
            if ((state == S_IDLE) && empty_o && done_any) begin
                irq_o    <= 1'b1;
                done_any <= 1'b0;
            end else if (irq_clear_i) begin
                irq_o <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!empty_o) begin
                        color_o  <= head_cmd.color;
                        x0_o     <= head_cmd.x0;
                        y0_o     <= head_cmd.y0;
                        width_o  <= head_cmd.width;
                        height_o <= head_cmd.height;
                        leg_o    <= leg_i;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Zero-width fills never raise cyc, so triggering would deadlock.
                    if (width_o == '0) begin
                        state <= S_IDLE;
                    end else begin
                        trig_o <= 1'b1;
                        state  <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (fill_busy_i) begin
                        trig_o <= 1'b0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!fill_busy_i) begin
                        done_any <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fill_cmd_queue.sv
module tb_fill_cmd_queue;
    localparam int COLORW = 16;
    localparam int RANGEW = 9;
    localparam int DEPTH  = 4;
    localparam int LOGD   = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              cmd_we_i = 1'b0;
    logic [COLORW-1:0] cmd_color_i = '0;
    logic [RANGEW-1:0] cmd_x0_i = '0;
    logic [RANGEW-1:0] cmd_y0_i = '0;
    logic [RANGEW-1:0] cmd_width_i = '0;
    logic [RANGEW-1:0] cmd_height_i = '0;
    logic [RANGEW-1:0] leg_i = '0;
    logic              full_o;
    logic              empty_o;
    logic [LOGD:0]     level_o;
    logic [COLORW-1:0] color_o;
    logic [RANGEW-1:0] x0_o;
    logic [RANGEW-1:0] y0_o;
    logic [RANGEW-1:0] width_o;
    logic [RANGEW-1:0] height_o;
    logic [RANGEW-1:0] leg_o;
    logic              trig_o;
    logic              fill_busy_i = 1'b0;
    logic              busy_o;
    logic              ovf_o;
    logic              irq_o;
    logic              irq_clear_i = 1'b0;

    int errors = 0;
    int checks = 0;

    fill_cmd_queue #(
        .COLORW (COLORW),
        .RANGEW (RANGEW),
        .DEPTH  (DEPTH),
        .LOGD   (LOGD)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_we_i     (cmd_we_i),
        .cmd_color_i  (cmd_color_i),
        .cmd_x0_i     (cmd_x0_i),
        .cmd_y0_i     (cmd_y0_i),
        .cmd_width_i  (cmd_width_i),
        .cmd_height_i (cmd_height_i),
        .leg_i        (leg_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .level_o      (level_o),
        .color_o      (color_o),
        .x0_o         (x0_o),
        .y0_o         (y0_o),
        .width_o      (width_o),
        .height_o     (height_o),
        .leg_o        (leg_o),
        .trig_o       (trig_o),
        .fill_busy_i  (fill_busy_i),
        .busy_o       (busy_o),
        .ovf_o        (ovf_o),
        .irq_o        (irq_o),
        .irq_clear_i  (irq_clear_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [15:0] c, input logic [8:0] x, input logic [8:0] y,
                        input logic [8:0] w, input logic [8:0] h);
        cmd_color_i  = c;
        cmd_x0_i     = x;
        cmd_y0_i     = y;
        cmd_width_i  = w;
        cmd_height_i = h;
        cmd_we_i     = 1'b1;
        tick();
        cmd_we_i     = 1'b0;
    endtask

    task automatic do_reset();
        fill_busy_i = 1'b0;
        irq_clear_i = 1'b0;
        cmd_we_i    = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic wait_trig();
        int n = 0;
        while (trig_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (trig_o !== 1'b1) begin errors++; $display("FAIL wait_trig: trig_o=%b required 1 within 20 cycles", trig_o); end
    endtask

    task automatic run_cmd(input logic [15:0] c, input logic [8:0] w, input int hold);
        wait_trig();
        checks++; if (color_o !== c) begin errors++; $display("FAIL run_color: got %h required %h", color_o, c); end
        checks++; if (width_o !== w) begin errors++; $display("FAIL run_width: got %0d required %0d", width_o, w); end
        fill_busy_i = 1'b1;
        tick();
        checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL run_trig_fall: got %b required 0", trig_o); end
        repeat (hold) tick();
        fill_busy_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #1;
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b required 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", full_o); end
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", level_o); end
        checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b required 0", trig_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        checks++; if ({irq_o, ovf_o} !== 2'b00) begin errors++; $display("FAIL reset_irq_ovf: got %b required 00", {irq_o, ovf_o}); end
        checks++; if (color_o !== 16'h0) begin errors++; $display("FAIL reset_color: got %h required 0", color_o); end
        do_reset();
    endtask

    task automatic test_single();
        leg_i = 9'd320;
        push(16'hF800, 9'd2, 9'd3, 9'd4, 9'd5);
        checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL single_empty_N: got %b required 0", empty_o); end
        checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL single_trig_N: got %b required 0", trig_o); end
        tick();
        checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL single_trig_N1: got %b required 0", trig_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_N1: got %b required 1", busy_o); end
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL single_level_N1: got %0d required 0", level_o); end
        leg_i = 9'd0;
        tick();
        checks++; if (trig_o !== 1'b1) begin errors++; $display("FAIL single_trig_N2: got %b required 1", trig_o); end
        checks++; if (color_o !== 16'hF800) begin errors++; $display("FAIL single_color: got %h required f800", color_o); end
        checks++; if ({x0_o, y0_o} !== {9'd2, 9'd3}) begin errors++; $display("FAIL single_xy: got %0d,%0d required 2,3", x0_o, y0_o); end
        checks++; if ({width_o, height_o} !== {9'd4, 9'd5}) begin errors++; $display("FAIL single_wh: got %0d,%0d required 4,5", width_o, height_o); end
        checks++; if (leg_o !== 9'd320) begin errors++; $display("FAIL single_leg: got %0d required 320", leg_o); end
        fill_busy_i = 1'b1;
        tick();
        checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL single_trig_fall: got %b required 0", trig_o); end
        repeat (49) tick();
        checks++; if ({color_o, leg_o, height_o} !== {16'hF800, 9'd320, 9'd5}) begin errors++; $display("FAIL single_hold: got %h/%0d/%0d required f800/320/5", color_o, leg_o, height_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_run: got %b required 1", busy_o); end
        fill_busy_i = 1'b0;
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b required 0", busy_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL single_irq_early: got %b required 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL single_irq: got %b required 1", irq_o); end
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL single_irq_clear: got %b required 0", irq_o); end
    endtask

    task automatic test_zero_width();
        push(16'h0A0A, 9'd0, 9'd0, 9'd1, 9'd1);
        wait_trig();
        fill_busy_i = 1'b1;
        tick();
        push(16'h00AA, 9'd1, 9'd1, 9'd0, 9'd2);
        push(16'h00BB, 9'd1, 9'd1, 9'd3, 9'd2);
        checks++; if (level_o !== 3'd2) begin errors++; $display("FAIL zw_level2: got %0d required 2", level_o); end
        fill_busy_i = 1'b0;
        tick();
        tick();
        checks++; if (level_o !== 3'd1) begin errors++; $display("FAIL zw_level1: got %0d required 1", level_o); end
        checks++; if (width_o !== 9'd0) begin errors++; $display("FAIL zw_width0: got %0d required 0", width_o); end
        tick();
        checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL zw_no_trig: got %b required 0", trig_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zw_discard_idle: got %b required 0", busy_o); end
        tick();
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL zw_level0: got %0d required 0", level_o); end
        tick();
        checks++; if (trig_o !== 1'b1) begin errors++; $display("FAIL zw_trig_second: got %b required 1", trig_o); end
        checks++; if ({color_o, width_o} !== {16'h00BB, 9'd3}) begin errors++; $display("FAIL zw_second_cmd: got %h/%0d required 00bb/3", color_o, width_o); end
        run_cmd(16'h00BB, 9'd3, 3);
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL zw_irq: got %b required 1", irq_o); end
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
    endtask

    task automatic test_irq_set_clear();
        push(16'h1234, 9'd5, 9'd6, 9'd7, 9'd8);
        run_cmd(16'h1234, 9'd7, 5);
        irq_clear_i = 1'b1;
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b required 1", irq_o); end
        tick();
        irq_clear_i = 1'b0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear_after: got %b required 0", irq_o); end
    endtask

    task automatic test_burst();
        fill_busy_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            push(16'(i), 9'(i), 9'(i), 9'(i + 1), 9'd1);
            if (i == 5) begin
                checks++; if ({full_o, level_o} !== {1'b1, 3'd4}) begin errors++; $display("FAIL burst_full: got full=%b level=%0d required 1/4", full_o, level_o); end
                checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL burst_ovf_early: got %b required 0", ovf_o); end
            end
        end
        checks++; if ({ovf_o, level_o} !== {1'b1, 3'd4}) begin errors++; $display("FAIL burst_ovf: got ovf=%b level=%0d required 1/4", ovf_o, level_o); end
        checks++; if ({busy_o, color_o} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL burst_first: got busy=%b color=%h required 1/0001", busy_o, color_o); end
        fill_busy_i = 1'b0;
        tick();
        for (int i = 2; i <= 5; i++) begin
            run_cmd(16'(i), 9'(i + 1), 4);
            checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL burst_irq_mid%0d: got %b required 0", i, irq_o); end
        end
        tick();
        checks++; if ({irq_o, empty_o} !== 2'b11) begin errors++; $display("FAIL burst_irq_end: got irq=%b empty=%b required 1/1", irq_o, empty_o); end
        repeat (10) tick();
        checks++; if ({trig_o, busy_o} !== 2'b00) begin errors++; $display("FAIL burst_sixth_dropped: got trig=%b busy=%b required 0/0", trig_o, busy_o); end
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        checks++; if ({irq_o, ovf_o} !== 2'b00) begin errors++; $display("FAIL burst_clear: got irq=%b ovf=%b required 0/0", irq_o, ovf_o); end
    endtask

    task automatic test_full_pushpop();
        push(16'h0010, 9'd0, 9'd0, 9'd1, 9'd1);
        wait_trig();
        fill_busy_i = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++)
            push(16'h0010 + 16'(i), 9'd0, 9'd0, 9'd2, 9'd2);
        checks++; if ({full_o, level_o} !== {1'b1, 3'd4}) begin errors++; $display("FAIL fpp_full: got full=%b level=%0d required 1/4", full_o, level_o); end
        fill_busy_i = 1'b0;
        tick();
        push(16'h0015, 9'd0, 9'd0, 9'd2, 9'd2);
        checks++; if ({full_o, level_o} !== {1'b1, 3'd4}) begin errors++; $display("FAIL fpp_level: got full=%b level=%0d required 1/4", full_o, level_o); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b required 0", ovf_o); end
        checks++; if (color_o !== 16'h0011) begin errors++; $display("FAIL fpp_head: got %h required 0011", color_o); end
        do_reset();
    endtask

    task automatic test_async_reset();
        push(16'h0020, 9'd1, 9'd1, 9'd1, 9'd1);
        wait_trig();
        fill_busy_i = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++)
            push(16'h0020 + 16'(i), 9'd1, 9'd1, 9'd2, 9'd2);
        checks++; if ({busy_o, level_o} !== {1'b1, 3'd3}) begin errors++; $display("FAIL ar_setup: got busy=%b level=%0d required 1/3", busy_o, level_o); end
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if ({level_o, empty_o, full_o} !== {3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL ar_fifo: got level=%0d empty=%b full=%b required 0/1/0", level_o, empty_o, full_o); end
        checks++; if ({busy_o, trig_o, irq_o, ovf_o} !== 4'b0000) begin errors++; $display("FAIL ar_flags: got %b required 0000", {busy_o, trig_o, irq_o, ovf_o}); end
        checks++; if ({color_o, width_o, leg_o} !== '0) begin errors++; $display("FAIL ar_regs: got %h/%0d/%0d required 0/0/0", color_o, width_o, leg_o); end
        fill_busy_i = 1'b0;
        tick();
        rst_i = 1'b0;
        repeat (10) tick();
        checks++; if ({trig_o, busy_o, empty_o} !== 3'b001) begin errors++; $display("FAIL ar_no_restart: got trig=%b busy=%b empty=%b required 0/0/1", trig_o, busy_o, empty_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_width();
        test_irq_set_clear();
        test_burst();
        test_full_pushpop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
